// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request load/store controller for a byte-addressed,
// little-endian data memory with combinational read and posedge write.
// Sub-word stores are done as read-modify-write of the aligned word.
//
// Handshake: the CPU side presents a request with req_i; it is accepted on the
// posedge where req_i && ready_o. ready_o is high only in IDLE, so requests
// made while busy are dropped (never queued). Completion is a one-cycle
// done_o pulse, with err_o qualifying it.
module mem_access_ctrl #(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0]  SZ_BYTE  = 2'b00;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_WORD  = 2'b10;
  localparam logic [31:0] MAX_BASE = 32'(MEM_BYTES - 4);

  state_t      state;

  // Request registers captured on accept
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic [31:0] base_i;
  logic        acc_err;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign state_o = state;
  assign base_i  = {addr_i[31:2], 2'b00};

  // Reject checks on the incoming request: reserved size, misalignment, range
  always_comb begin
    acc_err = 1'b0;
    if (size_i == 2'b11)                              acc_err = 1'b1;
    if ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00)) acc_err = 1'b1;
    if ((size_i == SZ_HALF) && addr_i[0])              acc_err = 1'b1;
    if (base_i > MAX_BASE)                             acc_err = 1'b1;
  end

  // Load path: move the addressed lane down to bit 0 and extend it
  always_comb begin
    shifted  = mem_data_i >> {lane_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = uns_q ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Store merge: old word with only the target lane bytes replaced
  always_comb begin
    merged = mem_data_i;
    if (size_q == SZ_BYTE) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (size_q == SZ_HALF) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end
  end

  // Control FSM; every output is registered and cleared asynchronously by reset,
  // so a reset during WR removes mem_write_o before the next edge can commit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ready_o     <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= 32'h0;
      mem_addr_o  <= 32'h0;
      mem_data_o  <= 32'h0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            lane_q  <= addr_i[1:0];
            wdata_q <= wdata_i[15:0];
            ready_o <= 1'b0;
            if (acc_err) begin
              state  <= DONE;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else if (we_i && (size_i == SZ_WORD)) begin
              state       <= WR;
              mem_write_o <= 1'b1;
              mem_addr_o  <= base_i;
              mem_data_o  <= wdata_i;
            end else begin
              state      <= RD;
              mem_read_o <= 1'b1;
              mem_addr_o <= base_i;
            end
          end
        end
        RD: begin
          mem_read_o <= 1'b0;
          if (we_q) begin
            state       <= WR;
            mem_write_o <= 1'b1;
            mem_data_o  <= merged;
          end else begin
            state      <= DONE;
            rdata_o    <= load_ext;
            mem_addr_o <= 32'h0;
            done_o     <= 1'b1;
            err_o      <= 1'b0;
          end
        end
        WR: begin
          state       <= DONE;
          mem_write_o <= 1'b0;
          mem_addr_o  <= 32'h0;
          mem_data_o  <= 32'h0;
          done_o      <= 1'b1;
          err_o       <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          done_o  <= 1'b0;
          err_o   <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
